// File: rtl/ece423_qsys_led_sequencer.sv
// ece423_qsys_led_sequencer: CPU-programmed LED step sequencer driving an 8-bit PIO over an Avalon-MM write master.
module ece423_qsys_led_sequencer #(
  parameter int PERIOD_W  = 24,
  parameter int NUM_STEPS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          s_address,
  input  logic                s_chipselect,
  input  logic                s_write_n,
  input  logic [31:0]         s_writedata,
  output logic [31:0]         s_readdata,
  output logic [2:0]          m_address,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [31:0]         m_writedata,
  input  logic                m_waitrequest
);
  typedef enum logic [1:0] {IDLE, WR_SET, WR_CLR, WR_STEP} state_t;
  state_t state, state_nxt;
  logic [7:0] val, val_nxt;
  logic en, oneshot, overrun, set_pending, clr_pending, step_pending, busy;
  logic [1:0] step;
  logic [PERIOD_W-1:0] period, cnt;
  logic [7:0] set_mask, clr_mask, wd;
  logic [7:0] pat [NUM_STEPS];
  logic wr, ctrl_wr, per_wr, set_wr, clr_wr, pat_wr, tick;
  logic set_req, clr_req, acc_set, acc_clr, acc_step, step_done, unused_wd;
  assign wr        = s_chipselect & ~s_write_n;
  assign wd        = s_writedata[7:0];
  assign ctrl_wr   = wr && s_address == 3'd0;
  assign per_wr    = wr && s_address == 3'd1;
  assign set_wr    = wr && s_address == 3'd2;
  assign clr_wr    = wr && s_address == 3'd3;
  assign pat_wr    = wr && s_address[2];
  assign unused_wd = ^s_writedata;
  assign tick      = en && cnt == period;
  // A SET/CLEAR write seen while idle is taken in the same edge, giving single-cycle latency.
  assign set_req   = set_pending | set_wr;
  assign clr_req   = clr_pending | clr_wr;
  assign acc_set   = state == IDLE && set_req;
  assign acc_clr   = state == IDLE && !set_req && clr_req;
  assign acc_step  = state == IDLE && !set_req && !clr_req && step_pending;
  assign step_done = state == WR_STEP && !m_waitrequest;
  assign busy      = state != IDLE || set_pending || clr_pending || step_pending;
  always_comb begin
    state_nxt = state;
    val_nxt   = val;
    if (acc_set) begin
      state_nxt = WR_SET;
      val_nxt   = set_pending ? set_mask : wd;
    end else if (acc_clr) begin
      state_nxt = WR_CLR;
      val_nxt   = clr_pending ? clr_mask : wd;
    end else if (acc_step) begin
      state_nxt = WR_STEP;
      val_nxt   = pat[step];
    end else if (state != IDLE && !m_waitrequest)
      state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      val   <= '0;
    end else begin
      state <= state_nxt;
      val   <= val_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      en           <= 1'b0;
      oneshot      <= 1'b0;
      overrun      <= 1'b0;
      set_pending  <= 1'b0;
      clr_pending  <= 1'b0;
      step_pending <= 1'b0;
      set_mask     <= '0;
      clr_mask     <= '0;
      step         <= '0;
      cnt          <= '0;
      period       <= '0;
      for (int i = 0; i < NUM_STEPS; i++) pat[i] <= '0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + PERIOD_W'(1);
      if (tick) begin
        step_pending <= 1'b1;
        if (step_pending && !acc_step) overrun <= 1'b1;
      end else if (acc_step)
        step_pending <= 1'b0;
      // A write landing on the accept edge becomes the next pending mask.
      set_mask    <= acc_set ? (set_pending && set_wr ? wd : '0) : set_wr ? set_mask | wd : set_mask;
      set_pending <= acc_set ? set_pending && set_wr : set_req;
      clr_mask    <= acc_clr ? (clr_pending && clr_wr ? wd : '0) : clr_wr ? clr_mask | wd : clr_mask;
      clr_pending <= acc_clr ? clr_pending && clr_wr : clr_req;
      if (step_done) begin
        step <= step + 2'd1;
        if (oneshot && step == 2'd3) begin
          en           <= 1'b0;
          step         <= '0;
          step_pending <= 1'b0;
          cnt          <= '0;
        end
      end
      if (ctrl_wr) begin
        en      <= s_writedata[0];
        oneshot <= s_writedata[1];
        if (s_writedata[3]) overrun <= 1'b0;
        if (s_writedata[0] && !en) begin
          cnt          <= '0;
          step         <= '0;
          step_pending <= 1'b1;
        end else if (!s_writedata[0])
          step_pending <= 1'b0;
      end
      if (per_wr) period <= s_writedata[PERIOD_W-1:0];
      if (pat_wr) pat[s_address[1:0]] <= wd;
    end
  end
  assign s_readdata   = s_address == 3'd0 ? {26'b0, step, overrun, busy, oneshot, en} :
                        s_address == 3'd1 ? 32'(period) :
                        s_address[2]      ? {24'b0, pat[s_address[1:0]]} : '0;
  assign m_chipselect = state != IDLE;
  assign m_write_n    = state == IDLE;
  assign m_address    = state == WR_SET ? 3'd4 : state == WR_CLR ? 3'd5 : 3'd0;
  assign m_writedata  = state == IDLE ? '0 : {24'b0, val};
endmodule

// File: tb/tb_ece423_qsys_led_sequencer.sv
// tb_ece423_qsys_led_sequencer: scoreboard bench; expected PIO writes are queued from stimulus and popped by a monitor.
module tb_ece423_qsys_led_sequencer;
  logic clk = 0, reset = 1;
  logic [2:0] s_address = 0;
  logic s_chipselect = 0, s_write_n = 1;
  logic [31:0] s_writedata = 0, s_readdata;
  logic [2:0] m_address;
  logic m_chipselect, m_write_n;
  logic [31:0] m_writedata;
  logic m_waitrequest = 0;

  ece423_qsys_led_sequencer #(.PERIOD_W(24), .NUM_STEPS(4)) dut (
    .clk(clk), .reset(reset),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_write_n(s_write_n),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_waitrequest(m_waitrequest));

  always #5 clk = ~clk;

  typedef struct {logic [2:0] a; logic [7:0] d;} wr_t;
  wr_t sb[$];
  int t_done[$];
  int cyc = 0, n_chk = 0, n_fail = 0, n_wr = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!reset && m_chipselect && !m_write_n && !m_waitrequest) begin
      n_wr++;
      t_done.push_back(cyc);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_mwrite: got addr %0d data 0x%0h expected no write", m_address, m_writedata);
      end else begin
        e = sb.pop_front();
        chk("mwrite_addr", 32'(m_address), 32'(e.a));
        chk("mwrite_data", m_writedata, {24'b0, e.d});
      end
    end
  end

  task automatic push(input logic [2:0] a, input logic [7:0] d);
    sb.push_back('{a, d});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s_address = a; s_chipselect = 1; s_write_n = 0; s_writedata = d;
    @(posedge clk);
    #1;
    s_chipselect = 0; s_write_n = 1;
  endtask

  task automatic cpu_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s_address = a; s_chipselect = 1; s_write_n = 1;
    #1 d = s_readdata;
    s_chipselect = 0;
  endtask

  task automatic drain(input string name, input int bound);
    int b;
    b = bound;
    while (sb.size() > 0 && b > 0) begin
      @(posedge clk);
      b--;
    end
    #1;
    chk(name, 32'(sb.size()), 0);
  endtask

  task automatic wait_idle(input string name, input int bound);
    logic [31:0] r;
    int b;
    b = bound;
    cpu_rd(0, r);
    while (r[2] && b > 0) begin
      cpu_rd(0, r);
      b--;
    end
    chk(name, 32'(r[2]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [7:0] pat [4];
    logic [7:0] m;
    logic is_set;
    int per, nops, hold, b, n0;

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 0;
    #1;
    chk("rst_cs", 32'(m_chipselect), 0);
    chk("rst_write_n", 32'(m_write_n), 1);
    chk("rst_addr", 32'(m_address), 0);
    chk("rst_data", m_writedata, 0);
    for (int i = 0; i < 8; i++) begin
      cpu_rd(3'(i), r);
      chk($sformatf("rst_reg%0d", i), r, 0);
    end

    // single SET from idle: strobe in the next cycle, idle in the one after
    push(4, 8'h5A);
    cpu_wr(2, 32'h5A);
    chk("lat_cs_n1", 32'(m_chipselect), 1);
    chk("lat_addr_n1", 32'(m_address), 4);
    chk("lat_data_n1", m_writedata, 32'h5A);
    cycles(1);
    chk("lat_cs_n2", 32'(m_chipselect), 0);

    // random SET/CLEAR bursts with random waitrequest stalls; writes emerge in issue order
    for (int it = 0; it < 20; it++) begin
      nops = $urandom_range(1, 2);
      hold = $urandom_range(0, 3);
      m_waitrequest = hold > 0;
      for (int k = 0; k < nops; k++) begin
        is_set = 1'($urandom_range(0, 1));
        m = 8'($urandom);
        push(is_set ? 3'd4 : 3'd5, m);
        cpu_wr(is_set ? 3'd2 : 3'd3, {24'b0, m});
      end
      repeat (hold) @(posedge clk);
      #1 m_waitrequest = 0;
      wait_idle("rand_idle", 20);
    end
    drain("rand_drain", 20);

    per = 9;
    for (int i = 0; i < 4; i++) begin
      pat[i] = 8'($urandom);
      cpu_wr(3'(4 + i), {24'b0, pat[i]});
    end
    cpu_wr(1, 32'(per));
    for (int i = 0; i < 4; i++) begin
      cpu_rd(3'(4 + i), r);
      chk("pat_rb", r, {24'b0, pat[i]});
    end
    cpu_rd(1, r);
    chk("period_rb", r, 32'(per));
    cpu_rd(2, r);
    chk("set_rd0", r, 0);
    cpu_rd(3, r);
    chk("clr_rd0", r, 0);

    // free-running sequence: STEP0 at once, then one step every PERIOD+1 cycles
    t_done.delete();
    for (int i = 0; i < 5; i++) push(0, pat[i % 4]);
    cpu_wr(0, 1);
    b = 200;
    while (t_done.size() < 5 && b > 0) begin
      @(posedge clk);
      b--;
    end
    cpu_wr(0, 0);
    chk("run_count", 32'(t_done.size()), 5);
    if (t_done.size() >= 5)
      for (int i = 1; i < 5; i++) chk("run_spacing", 32'(t_done[i] - t_done[i-1]), 32'(per + 1));
    drain("run_drain", 20);
    wait_idle("run_idle", 20);
    cycles(2 * (per + 1));

    // oneshot: exactly four steps then EN/STEP/BUSY all clear
    per = $urandom_range(3, 12);
    cpu_wr(1, 32'(per));
    for (int i = 0; i < 4; i++) push(0, pat[i]);
    cpu_wr(0, 3);
    drain("oneshot_drain", 4 * (per + 1) + 20);
    wait_idle("oneshot_idle", 20);
    cpu_rd(0, r);
    chk("oneshot_ctrl", r & 32'h35, 0);
    cycles(2 * (per + 1));

    // priority: SET > CLEAR > step while master stalled
    cpu_wr(1, 200);
    m_waitrequest = 1;
    push(4, 8'h40); push(4, 8'h10); push(5, 8'h01); push(0, pat[0]);
    cpu_wr(2, 32'h40);
    cpu_wr(0, 1);
    cpu_wr(2, 32'h10);
    cpu_wr(3, 32'h01);
    cycles(2);
    m_waitrequest = 0;
    drain("prio_drain", 30);
    wait_idle("prio_idle", 20);
    cpu_wr(0, 0);

    // stalled SET holds outputs 6 cycles; a SET arriving meanwhile follows
    m_waitrequest = 1;
    push(4, 8'h03); push(4, 8'h20);
    cpu_wr(2, 32'h03);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) m_waitrequest = 0;
      chk("stall_cs", 32'(m_chipselect), 1);
      chk("stall_addr", 32'(m_address), 4);
      chk("stall_data", m_writedata, 32'h03);
      if (i == 2) cpu_wr(2, 32'h20);
      else cycles(1);
    end
    drain("stall_drain", 20);
    wait_idle("stall_idle", 20);

    // overrun with PERIOD=0 and a stalled step write, then W1C
    cpu_wr(1, 0);
    m_waitrequest = 1;
    push(0, pat[0]);
    cpu_wr(0, 1);
    cycles(3);
    cpu_rd(0, r);
    chk("overrun_set", 32'(r[3]), 1);
    cpu_wr(0, 0);
    m_waitrequest = 0;
    drain("overrun_drain", 20);
    wait_idle("overrun_idle", 20);
    cpu_rd(0, r);
    chk("overrun_held", 32'(r[3]), 1);
    cpu_wr(0, 8);
    cpu_rd(0, r);
    chk("overrun_w1c", 32'(r[3]), 0);

    // reset in the middle of a stalled step write aborts it for good
    cpu_wr(1, 200);
    m_waitrequest = 1;
    cpu_wr(0, 1);
    cycles(2);
    chk("abort_pre_cs", 32'(m_chipselect), 1);
    n0 = n_wr;
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
    chk("abort_cs", 32'(m_chipselect), 0);
    @(negedge clk) reset = 0;
    cpu_rd(0, r);
    chk("abort_ctrl", r, 0);
    m_waitrequest = 0;
    cycles(30);
    chk("abort_nowrite", 32'(n_wr - n0), 0);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ece423_qsys_led_sequencer.md
ECE423_QSYS_LED_SEQUENCER -- requirements
Module: ece423_qsys_led_sequencer

Interface
REQ-001 The block SHALL have parameter PERIOD_W, default 24, the width of the step-period register and tick counter.
REQ-002 The block SHALL have parameter NUM_STEPS, default 4, fixed at 4, the number of pattern entries.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  sole clock, all logic on rising edge.
REQ-005 Port reset  input  1  synchronous active-high reset.
REQ-006 Ports s_address input 3, s_chipselect input 1, s_write_n input 1 (active-low), s_writedata input 32, s_readdata output 32: CPU Avalon-MM slave, zero wait states, combinational read.
REQ-007 Ports m_address output 3, m_chipselect output 1, m_write_n output 1, m_writedata output 32, m_waitrequest input 1: Avalon-MM write master to the 8-bit LED PIO (PIO offsets 0 = data, 4 = bit-set, 5 = bit-clear).

Function
REQ-008 Slave write strobe SHALL be s_chipselect AND NOT s_write_n; unmapped bits read 0.
REQ-009 Register map SHALL be: 0 CTRL {bit0 EN, bit1 ONESHOT, bit2 BUSY RO, bit3 OVERRUN W1C, bits5:4 STEP RO}; 1 PERIOD; 2 SET mask[7:0] (write-only, reads 0); 3 CLEAR mask[7:0] (write-only, reads 0); 4..7 STEP0..STEP3 pattern[7:0].
REQ-010 Tick counter SHALL increment each cycle while EN=1; on reaching PERIOD it SHALL return to 0 and raise step_pending; PERIOD=0 gives a tick every cycle.
REQ-011 Writing CTRL with EN 0->1 SHALL zero the counter and step index and set step_pending in the same edge, so STEP0 is output without waiting a period.
REQ-012 Writing EN=0 SHALL stop the counter and drop step_pending; a master write already in progress SHALL complete.
REQ-013 Writing SET SHALL OR writedata[7:0] into set_mask and set set_pending; CLEAR likewise into clr_mask/clr_pending.
REQ-014 If a SET/CLEAR write coincides with the FSM accepting that pending mask, the new mask SHALL become the next pending mask; no bits lost.
REQ-015 FSM states SHALL be IDLE, WR_SET, WR_CLR, WR_STEP; from IDLE priority is set_pending > clr_pending > step_pending, else stay IDLE.
REQ-016 Entering a WR state SHALL latch the mask/pattern and clear the corresponding pending flag; m_chipselect=1, m_write_n=0, m_address=4/5/0, m_writedata={24'b0,value} registered from the next cycle.
REQ-017 Master outputs SHALL hold stable while m_waitrequest=1; the cycle m_waitrequest=0 completes the write and the FSM returns to IDLE (one idle cycle minimum between writes).
REQ-018 Latency: SET write at cycle n with FSM IDLE and m_waitrequest=0 SHALL produce m_chipselect high in cycle n+1 and back to IDLE in cycle n+2.
REQ-019 WR_STEP completion SHALL advance STEP modulo 4; if ONESHOT=1 and completed step was 3, EN SHALL clear and STEP return to 0.
REQ-020 A tick while step_pending is still set SHALL set OVERRUN; the pending step is not duplicated.
REQ-021 BUSY SHALL read 1 when FSM is not IDLE or any pending flag is set.
REQ-022 Idle master outputs SHALL be m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.

Reset
REQ-023 reset SHALL force: FSM IDLE, all pending flags and masks 0, EN=ONESHOT=OVERRUN=0, STEP=0, counter 0, PERIOD 0, STEP0..3 0, master outputs idle values, s_readdata 0 for address 0.
REQ-024 reset asserted mid-write SHALL abort the master transaction in the same edge; no write is reissued afterwards.

Verification
REQ-025 STEP0..3=0x01,0x02,0x04,0x08, PERIOD=9, CTRL=0x1 -> PIO offset-0 writes 0x01 immediately, then every 10 cycles 0x02,0x04,0x08,0x01.
REQ-026 Same with CTRL=0x3 -> exactly four step writes, then CTRL reads EN=0, STEP=0, BUSY=0.
REQ-027 SET 0x10 and CLEAR 0x01 in consecutive cycles while a step is pending -> master order: offset 4 data 0x10, offset 5 data 0x01, offset 0 step.
REQ-028 m_waitrequest held high 5 cycles during WR_SET -> outputs stable 6 cycles, second SET 0x20 meanwhile yields a following offset-4 write of 0x20.
REQ-029 PERIOD=0, m_waitrequest high 3 cycles -> OVERRUN=1; writing CTRL bit3=1 -> OVERRUN=0.
REQ-030 reset pulsed during WR_STEP with m_waitrequest high -> next cycle m_chipselect=0, CTRL reads 0, no further master writes.
